// File: rtl/hamming_secded_stream.sv
`default_nettype none
// =============================================================================
// hamming_secded_stream
// Two-stage pipelined Hamming SECDED encode/decode with valid/ready handshake.
// Rev 1.0
// =============================================================================
module hamming_secded_stream #(
   parameter int DATA_W = 11,
   parameter int PAR_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_mode,
   input  logic [DATA_W+PAR_W:0]    in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_mode,
   output logic [DATA_W+PAR_W:0]    out_data,
   output logic [PAR_W-1:0]         out_syndrome,
   output logic                     out_err_single,
   output logic                     out_err_double,
   input  logic                     clr_cnt,
   output logic [CNT_W-1:0]         cnt_corr,
   output logic [CNT_W-1:0]         cnt_unc
);

   localparam int N    = DATA_W + PAR_W;
   localparam int CW_W = N + 1;

   if (DATA_W > (2 ** PAR_W) - PAR_W - 1) begin : g_param_check
      $error("hamming_secded_stream: DATA_W too large for PAR_W");
   end

   function automatic logic is_data_pos(input int p);
      return (p & (p - 1)) != 0;
   endfunction

   function automatic logic [CW_W-1:0] encode_word(input logic [DATA_W-1:0] d);
      logic [CW_W-1:0]   cw;
      logic [DATA_W-1:0] sh;
      cw = '0;
      sh = d;
      for (int p = 1; p <= N; p++) begin
         if (is_data_pos(p)) begin
            cw[p-1] = sh[0];
            sh      = sh >> 1;
         end
      end
      for (int k = 0; k < PAR_W; k++) begin
         if ((1 << k) <= N) begin
            for (int p = 1; p <= N; p++) begin
               if (is_data_pos(p) && (((p >> k) & 1) != 0))
                  cw[(1<<k)-1] = cw[(1<<k)-1] ^ cw[p-1];
            end
         end
      end
      cw[N] = ^cw[N-1:0];
      return cw;
   endfunction

   function automatic logic [PAR_W-1:0] syndrome_of(input logic [CW_W-1:0] cw);
      logic [PAR_W-1:0] s;
      s = '0;
      for (int p = 1; p <= N; p++) begin
         if (cw[p-1])
            s = s ^ PAR_W'(p);
      end
      return s;
   endfunction

   // Data bits are shifted in from the top so the first one collected lands at bit 0.
   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
      logic [DATA_W-1:0] d;
      int                cnt;
      d   = '0;
      cnt = 0;
      for (int p = 1; p <= N; p++) begin
         if (is_data_pos(p) && cnt < DATA_W) begin
            d   = (d >> 1) | (DATA_W'(cw[p-1]) << (DATA_W - 1));
            cnt = cnt + 1;
         end
      end
      return d;
   endfunction

   logic             s1_full_q, s1_full_d;
   logic             s1_mode_q, s1_mode_d;
   logic [CW_W-1:0]  s1_word_q, s1_word_d;
   logic [PAR_W-1:0] s1_syn_q,  s1_syn_d;
   logic             s1_par_q,  s1_par_d;

   logic             s2_full_q,   s2_full_d;
   logic             s2_mode_q,   s2_mode_d;
   logic [CW_W-1:0]  s2_data_q,   s2_data_d;
   logic [PAR_W-1:0] s2_syn_q,    s2_syn_d;
   logic             s2_single_q, s2_single_d;
   logic             s2_double_q, s2_double_d;

   logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
   logic [CNT_W-1:0] cnt_unc_q,  cnt_unc_d;

   logic             w_s2_open;
   logic             w_in_fire;
   logic             w_out_fire;
   logic [CW_W-1:0]  w_fix;
   logic [CW_W-1:0]  w_res_data;
   logic [PAR_W-1:0] w_res_syn;
   logic             w_res_single;
   logic             w_res_double;

   assign w_s2_open  = !s2_full_q || out_ready;
   assign in_ready   = !rst && (!s1_full_q || w_s2_open);
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = s2_full_q && out_ready;

   always_comb begin
      w_fix        = s1_word_q;
      w_res_data   = '0;
      w_res_syn    = '0;
      w_res_single = 1'b0;
      w_res_double = 1'b0;
      if (!s1_mode_q) begin
         w_res_data = encode_word(s1_word_q[DATA_W-1:0]);
      end else begin
         w_res_syn = s1_syn_q;
         if (s1_syn_q == '0) begin
            // Zero syndrome with odd parity means only the overall-parity bit flipped.
            w_res_single = s1_par_q;
         end else if (!s1_par_q) begin
            w_res_double = 1'b1;
         end else if (int'(s1_syn_q) <= N) begin
            w_res_single = 1'b1;
            for (int p = 1; p <= N; p++) begin
               if (s1_syn_q == PAR_W'(p))
                  w_fix[p-1] = ~w_fix[p-1];
            end
         end else begin
            w_res_double = 1'b1;
         end
         w_res_data = CW_W'(extract_data(w_fix));
      end
   end

   always_comb begin
      s1_full_d   = s1_full_q;
      s1_mode_d   = s1_mode_q;
      s1_word_d   = s1_word_q;
      s1_syn_d    = s1_syn_q;
      s1_par_d    = s1_par_q;
      s2_full_d   = s2_full_q;
      s2_mode_d   = s2_mode_q;
      s2_data_d   = s2_data_q;
      s2_syn_d    = s2_syn_q;
      s2_single_d = s2_single_q;
      s2_double_d = s2_double_q;

      if (w_in_fire) begin
         s1_full_d = 1'b1;
         s1_mode_d = in_mode;
         s1_word_d = in_data;
         s1_syn_d  = in_mode ? syndrome_of(in_data) : '0;
         s1_par_d  = in_mode & (^in_data);
      end else if (s1_full_q && w_s2_open) begin
         s1_full_d = 1'b0;
      end

      if (w_s2_open) begin
         s2_full_d = s1_full_q;
         if (s1_full_q) begin
            s2_mode_d   = s1_mode_q;
            s2_data_d   = w_res_data;
            s2_syn_d    = w_res_syn;
            s2_single_d = w_res_single;
            s2_double_d = w_res_double;
         end
      end
   end

   always_comb begin
      cnt_corr_d = cnt_corr_q;
      cnt_unc_d  = cnt_unc_q;
      if (clr_cnt) begin
         cnt_corr_d = '0;
         cnt_unc_d  = '0;
      end else if (w_out_fire && s2_mode_q) begin
         if (s2_single_q && cnt_corr_q != '1)
            cnt_corr_d = cnt_corr_q + 1'b1;
         if (s2_double_q && cnt_unc_q != '1)
            cnt_unc_d = cnt_unc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_full_q   <= 1'b0;
         s1_mode_q   <= 1'b0;
         s1_word_q   <= '0;
         s1_syn_q    <= '0;
         s1_par_q    <= 1'b0;
         s2_full_q   <= 1'b0;
         s2_mode_q   <= 1'b0;
         s2_data_q   <= '0;
         s2_syn_q    <= '0;
         s2_single_q <= 1'b0;
         s2_double_q <= 1'b0;
         cnt_corr_q  <= '0;
         cnt_unc_q   <= '0;
      end else begin
         s1_full_q   <= s1_full_d;
         s1_mode_q   <= s1_mode_d;
         s1_word_q   <= s1_word_d;
         s1_syn_q    <= s1_syn_d;
         s1_par_q    <= s1_par_d;
         s2_full_q   <= s2_full_d;
         s2_mode_q   <= s2_mode_d;
         s2_data_q   <= s2_data_d;
         s2_syn_q    <= s2_syn_d;
         s2_single_q <= s2_single_d;
         s2_double_q <= s2_double_d;
         cnt_corr_q  <= cnt_corr_d;
         cnt_unc_q   <= cnt_unc_d;
      end
   end

   assign out_valid      = s2_full_q;
   assign out_mode       = s2_mode_q;
   assign out_data       = s2_data_q;
   assign out_syndrome   = s2_syn_q;
   assign out_err_single = s2_single_q;
   assign out_err_double = s2_double_q;
   assign cnt_corr       = cnt_corr_q;
   assign cnt_unc        = cnt_unc_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_stream.sv
`default_nettype none
// =============================================================================
// tb_hamming_secded_stream
// Scoreboard bench: directed cases plus randomized traffic against a brute-force SECDED model.
// Rev 1.0
// =============================================================================
module tb_hamming_secded_stream;

   localparam int DATA_W = 11;
   localparam int PAR_W  = 4;
   localparam int CNT_W  = 2;
   localparam int N      = DATA_W + PAR_W;
   localparam int CW_W   = N + 1;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_mode = 1'b0;
   logic [CW_W-1:0]  in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_mode;
   logic [CW_W-1:0]  out_data;
   logic [PAR_W-1:0] out_syndrome;
   logic             out_err_single;
   logic             out_err_double;
   logic             clr_cnt = 1'b0;
   logic [CNT_W-1:0] cnt_corr;
   logic [CNT_W-1:0] cnt_unc;

   hamming_secded_stream #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
      .out_syndrome(out_syndrome), .out_err_single(out_err_single), .out_err_double(out_err_double),
      .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_unc(cnt_unc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic             mode;
      logic [CW_W-1:0]  data;
      logic [PAR_W-1:0] syn;
      logic             single;
      logic             dbl;
      int               acc;
      bit               lat;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [CW_W-1:0] m_encode(input logic [DATA_W-1:0] d);
      logic [CW_W-1:0] cw;
      int j;
      int s;
      cw = '0; j = 0; s = 0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = ((d >> j) & 1) != 0;
            j++;
         end
      end
      // Set parity bits so the XOR of all set positions becomes zero.
      for (int p = 1; p <= N; p++) if (cw[p-1]) s = s ^ p;
      for (int k = 0; k < PAR_W; k++) if (((s >> k) & 1) != 0) cw[(1<<k)-1] = 1'b1;
      cw[N] = ^cw[N-1:0];
      return cw;
   endfunction

   function automatic logic [DATA_W-1:0] m_extract(input logic [CW_W-1:0] cw);
      logic [DATA_W-1:0] d;
      int j;
      d = '0; j = 0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            d = d | (DATA_W'(cw[p-1]) << j);
            j++;
         end
      end
      return d;
   endfunction

   function automatic logic [PAR_W-1:0] m_syn(input logic [CW_W-1:0] cw);
      int s;
      s = 0;
      for (int p = 1; p <= N; p++) if (cw[p-1]) s = s ^ p;
      return PAR_W'(s);
   endfunction

   function automatic bit m_is_cw(input logic [CW_W-1:0] cw);
      return m_encode(m_extract(cw)) == cw;
   endfunction

   function automatic exp_t mk_model(input logic m, input logic [CW_W-1:0] d, input bit lat);
      exp_t e;
      logic [CW_W-1:0] one;
      logic [CW_W-1:0] t;
      bit found;
      e.mode = m; e.lat = lat; e.acc = 0;
      e.syn = '0; e.single = 1'b0; e.dbl = 1'b0;
      one = 1;
      if (!m) begin
         e.data = m_encode(d[DATA_W-1:0]);
      end else begin
         e.syn = m_syn(d);
         if (m_is_cw(d)) begin
            e.data = CW_W'(m_extract(d));
         end else begin
            // Nearest codeword by exhaustive single-bit search; none at distance 1 means uncorrectable.
            found = 1'b0;
            e.data = CW_W'(m_extract(d));
            for (int i = 0; i < CW_W; i++) begin
               t = d ^ (one << i);
               if (!found && m_is_cw(t)) begin
                  found  = 1'b1;
                  e.data = CW_W'(m_extract(t));
               end
            end
            e.single = found;
            e.dbl    = !found;
         end
      end
      return e;
   endfunction

   function automatic exp_t mk_const(input logic m, input logic [CW_W-1:0] data,
                                     input logic [PAR_W-1:0] syn, input logic s,
                                     input logic dbl, input bit lat);
      exp_t e;
      e.mode = m; e.data = data; e.syn = syn; e.single = s; e.dbl = dbl;
      e.acc = 0; e.lat = lat;
      return e;
   endfunction

   // ---------------- driver ----------------
   task automatic issue(input logic m, input logic [CW_W-1:0] d, input exp_t e);
      int waited;
      waited = 0;
      in_valid = 1'b1; in_mode = m; in_data = d;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
      end else begin
         e.acc = cyc;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic m, input logic [CW_W-1:0] d);
      issue(m, d, mk_model(m, d, 1'b0));
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 300) begin
         waited++;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   // ---------------- monitor ----------------
   logic        prev_valid = 1'b0;
   logic        prev_hs    = 1'b0;
   logic [31:0] held_bus   = '0;
   int          mc_corr    = 0;
   int          mc_unc     = 0;

   always @(negedge clk) begin
      exp_t e;
      logic inc_c, inc_u;
      inc_c = 1'b0; inc_u = 1'b0;
      if (rst) begin
         sb.delete();
         prev_valid = 1'b0; prev_hs = 1'b0;
         mc_corr = 0; mc_unc = 0;
      end else begin
         check("cnt_corr", 32'(cnt_corr), 32'(mc_corr));
         check("cnt_unc",  32'(cnt_unc),  32'(mc_unc));
         if (prev_valid && !prev_hs) begin
            check("valid_hold", 32'(out_valid), 32'd1);
            check("data_hold", 32'({out_mode, out_data, out_syndrome, out_err_single, out_err_double}), held_bus);
         end else if (out_valid && sb.size() != 0 && sb[0].lat) begin
            check("latency", 32'(cyc - sb[0].acc), 32'd2);
         end
         held_bus = 32'({out_mode, out_data, out_syndrome, out_err_single, out_err_double});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_output: data %0h with empty scoreboard", out_data);
            end else begin
               e = sb.pop_front();
               check("out_mode",   32'(out_mode),       32'(e.mode));
               check("out_data",   32'(out_data),       32'(e.data));
               check("out_syn",    32'(out_syndrome),   32'(e.syn));
               check("err_single", 32'(out_err_single), 32'(e.single));
               check("err_double", 32'(out_err_double), 32'(e.dbl));
               inc_c = e.mode && e.single;
               inc_u = e.mode && e.dbl;
            end
         end
         if (clr_cnt) begin
            mc_corr = 0; mc_unc = 0;
         end else begin
            if (inc_c && mc_corr < CMAX) mc_corr++;
            if (inc_u && mc_unc < CMAX) mc_unc++;
         end
         prev_valid = out_valid;
         prev_hs    = out_valid && out_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [CW_W-1:0] bp_words [4];
   bit              rnd_done = 1'b0;

   initial begin
      int idx;
      logic [CW_W-1:0] d;
      logic [CW_W-1:0] one;
      int r, i, j;
      one = 1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data), 32'd0);
      check("rst_flags",     32'({out_mode, out_syndrome, out_err_single, out_err_double}), 32'd0);
      check("rst_cnt",       32'({cnt_corr, cnt_unc}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Back-to-back encodes with fixed latency
      issue(1'b0, 16'h0001, mk_const(1'b0, 16'h8007, 4'd0, 1'b0, 1'b0, 1'b1));
      issue(1'b0, 16'h07FF, mk_const(1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b1));
      issue(1'b0, 16'h0000, mk_const(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1));
      drain();

      // Decode: single error, overall-parity error, double error
      issue(1'b1, 16'h8027, mk_const(1'b1, 16'h0001, 4'd6, 1'b1, 1'b0, 1'b1));
      drain();
      check("tp_cnt_corr1", 32'(cnt_corr), 32'd1);
      issue(1'b1, 16'h0007, mk_const(1'b1, 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1));
      drain();
      check("tp_cnt_corr2", 32'(cnt_corr), 32'd2);
      issue(1'b1, 16'h8227, mk_const(1'b1, 16'h0025, 4'hC, 1'b0, 1'b1, 1'b1));
      drain();
      check("tp_cnt_unc1", 32'(cnt_unc), 32'd1);

      // Backpressure: output stalled 6 cycles while 4 words are offered
      bp_words[0] = 16'h0123; bp_words[1] = 16'h0456;
      bp_words[2] = 16'h0789; bp_words[3] = 16'h00AB;
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         out_ready = (c >= 6);
         in_valid  = (idx < 4);
         in_mode   = 1'b0;
         in_data   = bp_words[idx < 4 ? idx : 3];
         @(negedge clk);
         if (c == 5) begin
            check("bp_accepted", 32'(idx), 32'd2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
         end
         if (c >= 6 && c <= 9)
            check("bp_no_gap", 32'(out_valid && out_ready), 32'd1);
         if (in_valid && in_ready) begin
            sb.push_back(mk_model(1'b0, bp_words[idx], 1'b0));
            idx++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_all_accepted", 32'(idx), 32'd4);
      drain();

      // Counter saturation and clear priority
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      check("clr_cnt_zero", 32'({cnt_corr, cnt_unc}), 32'd0);
      for (int k = 0; k < 5; k++) begin
         d = m_encode(DATA_W'($urandom)) ^ (one << $urandom_range(0, CW_W - 1));
         send(1'b1, d);
      end
      drain();
      check("cnt_corr_sat", 32'(cnt_corr), 32'd3);
      d = m_encode(DATA_W'($urandom)) ^ (one << 4);
      send(1'b1, d);
      @(posedge clk); #1;
      check("clr_hs_valid", 32'(out_valid), 32'd1);
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      check("clr_priority", 32'(cnt_corr), 32'd0);
      drain();

      // Reset with two words in flight
      send(1'b1, 16'h8027);
      drain();
      out_ready = 1'b0;
      send(1'b0, 16'h0555);
      send(1'b0, 16'h02AA);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_cnt", 32'({cnt_corr, cnt_unc}), 32'd0);
      out_ready = 1'b1;
      issue(1'b0, 16'h0001, mk_const(1'b0, 16'h8007, 4'd0, 1'b0, 1'b0, 1'b1));
      drain();

      // Randomized traffic with random backpressure and occasional clears
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               if ($urandom_range(0, 1) == 0) begin
                  send(1'b0, CW_W'($urandom));
               end else begin
                  d = m_encode(DATA_W'($urandom));
                  r = $urandom_range(0, 9);
                  if (r >= 4 && r <= 6) begin
                     d = d ^ (one << $urandom_range(0, CW_W - 1));
                  end else if (r >= 7 && r <= 8) begin
                     i = $urandom_range(0, CW_W - 1);
                     j = (i + $urandom_range(1, CW_W - 1)) % CW_W;
                     d = d ^ (one << i) ^ (one << j);
                  end else if (r == 9) begin
                     d = CW_W'($urandom);
                  end
                  send(1'b1, d);
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
               clr_cnt   = ($urandom_range(0, 40) == 0);
            end
         end
      join
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      drain();
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hamming_secded_stream.md
Name: hamming_secded_stream

Overview:
- Parametrised, pipelined Hamming SECDED codec with a valid/ready stream interface.
- Each transaction carries its own mode bit:
  - encode: data word to codeword;
  - decode: codeword to corrected data plus error status.
- Generalises the fixed 11-bit combinational encoder to any legal data width.
- Adds an overall-parity bit, single-error correction, double-error detection, backpressure and saturating error statistics.
- Sits between the memory/link datapath and its consumers.

Parameters:
- DATA_W, 11, data bits per word. Must satisfy DATA_W <= 2^PAR_W - PAR_W - 1; otherwise elaboration fails.
- PAR_W, 4, number of Hamming parity bits.
- CNT_W, 16, width of each saturating error counter.
- Derived, not overridable: N = DATA_W + PAR_W; CW_W = N + 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_mode  in  1  0 = encode, 1 = decode; sampled with in_data.
- in_data  in  CW_W  encode: low DATA_W bits are data, upper bits ignored. Decode: full codeword.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- out_mode  out  1  mode of the transaction being presented.
- out_data  out  CW_W  encode: codeword. Decode: corrected data, zero-extended.
- out_syndrome  out  PAR_W  decode: syndrome. Encode: 0.
- out_err_single  out  1  decode: one error found and corrected.
- out_err_double  out  1  decode: uncorrectable error.
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_corr  out  CNT_W  count of corrected transactions.
- cnt_unc  out  CNT_W  count of uncorrectable transactions.

Behaviour:
- Codeword layout:
  - Hamming position p (1..N) maps to codeword bit p-1.
  - Parity bit k sits at position 2^k.
  - Data bits fill the non-power-of-two positions in ascending order, data bit 0 first.
  - Parity k is the XOR of all positions with bit k of p set.
  - Bit N is the overall parity: XOR of bits 0..N-1, so total parity is even.
  - With the default parameters, bits 0..14 match the existing encoder exactly.
- Decode:
  - Syndrome S = XOR of p over all set positions; P = XOR of all CW_W bits.
  - S=0, P=0: no error.
  - S!=0, P=1, S<=N: flip bit S-1, then extract data; err_single=1.
  - S=0, P=1: error in the overall-parity bit; data is unaffected; err_single=1.
  - S!=0, P=0: err_double=1; out_data = uncorrected extracted data.
  - S>N, P=1 (impossible position): err_double=1.
- Pipeline:
  - Two register stages. Stage 1 registers input and mode, plus the syndrome/parity for decode. Stage 2 registers the result and flags.
  - Latency is 2 cycles from the acceptance edge to out_valid when not stalled. Throughput is 1 word per cycle.
  - A stage loads when it is empty or its contents leave in the same cycle.
  - in_ready = !stage1_full OR stage1 advances this cycle. in_ready is combinational from out_ready.
  - Once out_valid is high, out_* stay stable until out_valid && out_ready.
  - Order is preserved. No word is dropped or duplicated.
- Counters:
  - Each counter increments by 1 on the handshake cycle (out_valid && out_ready) of a decode result with the matching flag.
  - Counters saturate at 2^CNT_W-1.
  - clr_cnt has priority over a simultaneous increment; the result is 0.
- Reset:
  - Both stages empty; in_ready=0 during rst.
  - out_valid=0; out_data, out_syndrome, out_mode and flags = 0; counters = 0.
  - Reset mid-stream discards in-flight words.
  - in_ready=1 in the first cycle after rst deasserts.
- Status flags and out_syndrome are 0 for encode transactions.

Test Plan:
- Encode 11'h001, then 11'h7FF, then 11'h000 (back-to-back, out_ready=1) -> out_data 16'h8007, 16'hFFFF, 16'h0000 on 3 consecutive cycles, 2 cycles after each acceptance; no error flags.
- Decode 16'h8027 (bit 5 flipped) -> out_data 11'h001, out_syndrome 6, err_single=1, cnt_corr=1. Decode 16'h0007 (overall bit flipped) -> out_data 11'h001, syndrome 0, err_single=1, cnt_corr=2.
- Decode 16'h8227 (bits 5 and 9 flipped) -> err_double=1, err_single=0, cnt_unc=1.
- Backpressure:
  - Stimulus: out_ready=0 for 6 cycles while in_valid=1 with 4 distinct words.
  - Required: exactly 2 words accepted and in_ready=0 after that; out_data held stable.
  - On release, all 4 words emerge in order without gaps, and none is lost.
- Counters with CNT_W=2:
  - 5 single-error decodes -> cnt_corr saturates at 3.
  - clr_cnt asserted on the same cycle as a 6th single-error handshake -> cnt_corr=0.
- Reset with 2 words in flight -> out_valid=0 next cycle, counters 0; a subsequent encode of 11'h001 still returns 16'h8007.
